// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: PC source selects,
// sequencer states, the NOP instruction word and the load-use test.
package pipeline_hazard_ctrl_pkg;

  // PC source select driven into the PC mux
  localparam logic [1:0] PC_SRC_SEQ = 2'd0;  // PC+4
  localparam logic [1:0] PC_SRC_BR  = 2'd1;  // branch target from MEM
  localparam logic [1:0] PC_SRC_J   = 2'd2;  // j/jal target from ID
  localparam logic [1:0] PC_SRC_JR  = 2'd3;  // jr register target from ID

  // Sequencer states (kept as plain constants for compatibility with older blocks)
  localparam logic [0:0] STATE_RUN  = 1'b0;
  localparam logic [0:0] STATE_HOLD = 1'b1;

  // Encoding loaded into IF/ID on a flush (sll $0,$0,0)
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // A lw in EX feeds a register read by the instruction in ID. Writes to $0 are
  // discarded by the register file, so they can never create a hazard.
  function automatic logic isLoadUse(input logic       exMemRead,
                                     input logic [4:0] exRt,
                                     input logic [4:0] idRs,
                                     input logic [4:0] idRt,
                                     input logic       idUsesRt);
    return exMemRead && (exRt != 5'd0) &&
           ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc until the maximum value, then hold there
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Control outputs are a
// Mealy function of the RUN/HOLD state and the same-cycle hazard inputs, so they
// reach the pipe-register enables with zero latency. Only the state and the
// event counters are registered.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             ifid_jump,
  input  logic             ifid_jr,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_br_taken,
  input  logic             ext_hold_req,
  output logic             ext_hold_ack,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  logic [0:0] state;
  logic [0:0] nextState;
  logic       stallInc;
  logic       flushInc;
  logic       holdInc;

  // Prioritised hazard decode: hold, branch, jr, jump, load-use. The if/else
  // chain only looks at a lower-priority input once every higher one is known
  // inactive, so X on an ignored input cannot reach the outputs.
  always_comb begin
    // NOTE: every output gets a default before the branches; any path that left
    // one unassigned would infer a latch instead of combinational logic.
    nextState    = state;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    pc_src       = PC_SRC_SEQ;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    pipe_hold    = 1'b0;
    ext_hold_ack = 1'b0;
    stallInc     = 1'b0;
    flushInc     = 1'b0;
    holdInc      = 1'b0;

    if (ext_hold_req) begin
      if (state == STATE_HOLD) begin
        // Frozen: EX/MEM is held too, so a taken branch is re-seen on exit
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        pipe_hold    = 1'b1;
        ext_hold_ack = 1'b1;
        holdInc      = 1'b1;
      end else begin
        // Entry cycle behaves as idle RUN; the freeze starts next cycle
        nextState = STATE_HOLD;
      end
    end else begin
      nextState = STATE_RUN;
      if (exmem_br_taken) begin
        // Everything younger than MEM is wrong-path
        pc_src      = PC_SRC_BR;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flushInc    = 1'b1;
      end else if (ifid_jr) begin
        pc_src     = PC_SRC_JR;
        ifid_flush = 1'b1;
        flushInc   = 1'b1;
      end else if (ifid_jump) begin
        pc_src     = PC_SRC_J;
        ifid_flush = 1'b1;
        flushInc   = 1'b1;
      end else if (isLoadUse(idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt)) begin
        // One bubble: the lw moves on to MEM, so the hazard clears next cycle
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        stallInc   = 1'b1;
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (!reset) begin
      state <= STATE_RUN;
    end else begin
      state <= nextState;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallInc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flushInc),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uHoldCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (holdInc),
    .count (hold_cnt)
  );

endmodule
